// File: rtl/credential_link_pkg.sv
// Shared types and helpers for the credential serial link transmitter.
// Holds the FSM state type, frame size, keystream defaults and LFSR step.
package credential_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    localparam int FRAME_BITS = 11;

    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_DEFAULT_TAPS = 16'hB400;

    // One Galois step: shift right, fold taps back in when a 1 falls out.
    function automatic logic [15:0] lfsr_step(
        input logic [15:0] state,
        input logic [15:0] taps
    );
        logic [15:0] nxt;
        nxt = state >> 1;
        if (state[0]) begin
            nxt = nxt ^ taps;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/cred_fifo.sv
// Small synchronous FIFO buffering credential bytes ahead of the serialiser.
// Ports: clk, reset, push/push_data, pop/head, count, full, empty.
module cred_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    // Fullness is judged before any same-cycle pop frees a slot.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/credential_link_tx.sv
// Buffers credential bytes, XORs them with an LFSR keystream and sends them
// as framed serial: start, 8 data LSB first, even parity, stop.
// Ports: clk, reset, data_in/data_valid (push), key_seed/key_load,
// ready, tx_serial, tx_busy, overflow.
module credential_link_tx
    import credential_link_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [15:0] LFSR_TAPS    = LFSR_DEFAULT_TAPS,
    parameter logic [15:0] LFSR_DEFAULT = LFSR_DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  data_in,
    input  logic        data_valid,
    input  logic [15:0] key_seed,
    input  logic        key_load,
    output logic        ready,
    output logic        tx_serial,
    output logic        tx_busy,
    output logic        overflow
);

    localparam int CW  = $clog2(CLKS_PER_BIT);
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [FCW-1:0] DEPTH_CNT = FCW'(FIFO_DEPTH);

    tx_state_e       state;
    tx_state_e       state_nx;
    logic [CW-1:0]   bit_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift_reg;
    logic            parity_bit;
    logic [15:0]     lfsr;

    logic [7:0]      fifo_head;
    logic [FCW-1:0]  fifo_count;
    logic            fifo_full;
    logic            fifo_empty;

    logic            bit_end;
    logic            pop;
    logic            push_ok;
    logic            key_ok;
    logic            busy_nx;
    logic [7:0]      cipher_nx;
    logic [15:0]     seed_eff;

    cred_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (data_valid),
        .push_data (data_in),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign ready     = (fifo_count < DEPTH_CNT);
    assign push_ok   = data_valid && !fifo_full;
    assign bit_end   = (bit_cnt == BIT_LAST);
    assign cipher_nx = fifo_head ^ lfsr[7:0];
    // An all-zero seed would freeze the LFSR.
    assign seed_eff  = (key_seed == '0) ? 16'h0001 : key_seed;
    // Reseeding only between bursts keeps both ends' keystreams aligned.
    assign key_ok    = (state == ST_IDLE) && fifo_empty;

    always_comb begin
        pop = 1'b0;
        case (state)
            ST_IDLE: pop = !fifo_empty;
            ST_STOP: pop = bit_end && !fifo_empty;
            default: pop = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) state_nx = ST_START;
            end
            ST_START: begin
                if (bit_end) state_nx = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end && bit_idx == 3'd7) state_nx = ST_PARITY;
            end
            ST_PARITY: begin
                if (bit_end) state_nx = ST_STOP;
            end
            ST_STOP: begin
                if (bit_end) state_nx = fifo_empty ? ST_IDLE : ST_START;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Landing in IDLE implies the FIFO was empty, so the only thing that
    // can keep it occupied is a byte accepted on this same edge.
    assign busy_nx = (state_nx != ST_IDLE) || push_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            lfsr       <= LFSR_DEFAULT;
            tx_serial  <= 1'b1;
            tx_busy    <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state   <= state_nx;
            tx_busy <= busy_nx;

            if (data_valid && fifo_full) begin
                overflow <= 1'b1;
            end

            if (state == ST_IDLE || bit_end) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (pop) begin
                shift_reg  <= cipher_nx;
                parity_bit <= ^cipher_nx;
                bit_idx    <= '0;
                tx_serial  <= 1'b0;
            end else if (key_load && key_ok) begin
                lfsr <= seed_eff;
            end

            if (bit_end) begin
                case (state)
                    ST_START: tx_serial <= shift_reg[0];
                    ST_DATA: begin
                        shift_reg <= shift_reg >> 1;
                        lfsr      <= lfsr_step(lfsr, LFSR_TAPS);
                        bit_idx   <= bit_idx + 1'b1;
                        tx_serial <= (bit_idx == 3'd7) ? parity_bit
                                                       : shift_reg[1];
                    end
                    ST_PARITY: tx_serial <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule
